// File: rtl/scoreboard_hazard_unit_pkg.sv
// hazard_pkg: latency classes and default timing constants for the scoreboard hazard unit.
package hazard_pkg;
    typedef enum logic [1:0] {LAT_ALU = 2'd0, LAT_LOAD = 2'd1, LAT_MUL = 2'd2} lat_class_e;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_LOAD_LAT    = 1;
    localparam int DEF_MUL_LAT     = 3;
    localparam int DEF_ECALL_REG   = 17;
    localparam int DEF_ECALL_EXTRA = 1;
    localparam int DEF_CNT_W       = 3;
endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// scoreboard_hazard_unit_if: ID-stage request and stall/pending response bundle.
interface scoreboard_hazard_unit_if #(
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
);
    logic                id_valid;
    logic [AW-1:0]       rs1;
    logic [AW-1:0]       rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic [AW-1:0]       id_rd;
    logic                id_reg_write;
    logic [1:0]          id_lat_class;
    logic                is_ecall;
    logic                flush;
    logic                is_stall;
    logic [NUM_REGS-1:0] pending;
    logic [31:0]         stall_cycles;
    modport master (
        output id_valid, rs1, rs2, use_rs1, use_rs2, id_rd, id_reg_write, id_lat_class, is_ecall, flush,
        input  is_stall, pending, stall_cycles
    );
    modport slave (
        input  id_valid, rs1, rs2, use_rs1, use_rs2, id_rd, id_reg_write, id_lat_class, is_ecall, flush,
        output is_stall, pending, stall_cycles
    );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_counter.sv
// sb_counter: one saturating countdown entry that loads the larger of its next value and a new latency.
module sb_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d, dec;
    always_comb begin
        dec   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        cnt_d = load && load_val > dec ? load_val : dec;
    end
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register countdown scoreboard issuing ID-stage stalls for RAW and ecall hazards.
// Optional stall statistics counter enabled by HAZ_STATS_EN.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int LOAD_LAT    = DEF_LOAD_LAT,
    parameter int MUL_LAT     = DEF_MUL_LAT,
    parameter int ECALL_REG   = DEF_ECALL_REG,
    parameter int ECALL_EXTRA = DEF_ECALL_EXTRA,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic clk,
    input logic reset,
    scoreboard_hazard_unit_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT ? LOAD_LAT : MUL_LAT) + ECALL_EXTRA;

    if (MAX_LAT > 2 ** CNT_W - 1) begin : g_bad_cnt_w
        $fatal(1, "CNT_W too narrow for configured latencies");
    end

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat, ecall_lat, ecnt;
    logic raw, eh, stall, issue;

    always_comb begin
        lat       = bus.id_lat_class == LAT_LOAD ? CNT_W'(LOAD_LAT) :
                    bus.id_lat_class == LAT_MUL  ? CNT_W'(MUL_LAT)  : '0;
        ecall_lat = lat + CNT_W'(ECALL_EXTRA);
        raw       = (bus.use_rs1 && bus.rs1 != '0 && cnt[bus.rs1] != '0) ||
                    (bus.use_rs2 && bus.rs2 != '0 && cnt[bus.rs2] != '0);
        eh        = bus.is_ecall && ecnt != '0;
        stall     = bus.id_valid && !bus.flush && (raw || eh);
        issue     = bus.id_valid && !bus.flush && !stall && bus.id_reg_write && bus.id_rd != '0;
    end

    // x0 is hardwired, so it gets no counter and can never look pending
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign cnt[r] = '0;
        end else begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .load     (issue && bus.id_rd == AW'(r)),
                .load_val (lat),
                .cnt      (cnt[r])
            );
        end
        assign bus.pending[r] = cnt[r] != '0;
    end

    sb_counter #(.CNT_W(CNT_W)) u_ecnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue && bus.id_rd == AW'(ECALL_REG)),
        .load_val (ecall_lat),
        .cnt      (ecnt)
    );

    assign bus.is_stall = stall;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    always_comb stall_cycles_d = stall_cycles_q + {31'd0, stall};
    always_ff @(posedge clk) begin
        if (!reset) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end
    assign bus.stall_cycles = stall_cycles_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed self-checking bench for scoreboard_hazard_unit.
module tb_scoreboard_hazard_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   exp_st = 0;

    always #5 clk = ~clk;

    scoreboard_hazard_unit_if #(.NUM_REGS(32)) bus ();

    scoreboard_hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.rs1          = '0;
        bus.rs2          = '0;
        bus.use_rs1      = 1'b0;
        bus.use_rs2      = 1'b0;
        bus.id_rd        = '0;
        bus.id_reg_write = 1'b0;
        bus.id_lat_class = LAT_ALU;
        bus.is_ecall     = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic ins(input logic [4:0] rd, input logic rw, input logic [1:0] cls,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                       input logic ec);
        bus.id_valid     = 1'b1;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_lat_class = cls;
        bus.rs1          = s1;
        bus.use_rs1      = u1;
        bus.rs2          = s2;
        bus.use_rs2      = u2;
        bus.is_ecall     = ec;
        bus.flush        = 1'b0;
    endtask

    // Hold the current ID instruction for n cycles, expecting a stall in each.
    task automatic stall_for(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            #4;
            chk(tag, {31'd0, bus.is_stall}, 32'd1);
            exp_st++;
            tick();
        end
        #4;
        chk({tag, "_release"}, {31'd0, bus.is_stall}, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
        #4;
        chk("rst_stall", {31'd0, bus.is_stall}, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_stats", bus.stall_cycles, 32'd0);
        tick();

        // load-use: one bubble
        ins(5, 1, LAT_LOAD, 0, 0, 0, 0, 0);
        #4;
        chk("load_issue_stall", {31'd0, bus.is_stall}, 32'd0);
        tick();
        ins(6, 1, LAT_ALU, 5, 1, 1, 1, 0);
        #4;
        chk("load_use_pending5", {31'd0, bus.pending[5]}, 32'd1);
        tick();
        bus.id_valid = 1'b1;
        #4;
        chk("load_use_pending5_clr", {31'd0, bus.pending[5]}, 32'd0);
        chk("load_use_go", {31'd0, bus.is_stall}, 32'd0);
        exp_st++;
        tick();

        // mul then immediate consumer: three bubbles
        ins(7, 1, LAT_MUL, 0, 0, 0, 0, 0);
        tick();
        ins(8, 1, LAT_ALU, 0, 0, 7, 1, 0);
        stall_for("mul_k1", 3);

        // mul then consumer after two idle cycles: one bubble
        ins(7, 1, LAT_MUL, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        ins(8, 1, LAT_ALU, 7, 1, 0, 0, 0);
        stall_for("mul_k3", 1);

        // x0 is never tracked
        ins(0, 1, LAT_MUL, 0, 0, 0, 0, 0);
        tick();
        ins(3, 1, LAT_ALU, 0, 1, 0, 1, 0);
        #4;
        chk("x0_stall", {31'd0, bus.is_stall}, 32'd0);
        chk("x0_pending", {31'd0, bus.pending[0]}, 32'd0);
        tick();

        // ecall waits on x17
        ins(17, 1, LAT_ALU, 0, 0, 0, 0, 0);
        tick();
        ins(0, 0, LAT_ALU, 0, 0, 0, 0, 1);
        stall_for("ecall_alu", 1);
        ins(17, 1, LAT_LOAD, 0, 0, 0, 0, 0);
        tick();
        ins(0, 0, LAT_ALU, 0, 0, 0, 0, 1);
        stall_for("ecall_load", 2);

        // WAW: later shorter load must not shorten the outstanding mul
        ins(9, 1, LAT_MUL, 0, 0, 0, 0, 0);
        tick();
        ins(9, 1, LAT_LOAD, 0, 0, 0, 0, 0);
        #4;
        chk("waw_issue_stall", {31'd0, bus.is_stall}, 32'd0);
        tick();
        ins(10, 1, LAT_ALU, 9, 1, 0, 0, 0);
        stall_for("waw_consumer", 2);

        // flush beats stall and suppresses issue
        ins(5, 1, LAT_LOAD, 0, 0, 0, 0, 0);
        tick();
        ins(6, 1, LAT_MUL, 5, 1, 0, 0, 0);
        bus.flush = 1'b1;
        #4;
        chk("flush_stall", {31'd0, bus.is_stall}, 32'd0);
        chk("flush_pending5", {31'd0, bus.pending[5]}, 32'd1);
        tick();
        idle();
        #4;
        chk("flush_no_issue", {31'd0, bus.pending[6]}, 32'd0);
        chk("flush_pending_all", bus.pending, 32'd0);
        tick();

`ifdef HAZ_STATS_EN
        chk("stats_total", bus.stall_cycles, 32'(exp_st));
`else
        chk("stats_total", bus.stall_cycles, 32'd0);
`endif

        // reset in the middle of a mul stall
        ins(7, 1, LAT_MUL, 0, 0, 0, 0, 0);
        tick();
        ins(8, 1, LAT_ALU, 7, 1, 0, 0, 0);
        #4;
        chk("rst_mid_stall_before", {31'd0, bus.is_stall}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #4;
        chk("rst_mid_stall", {31'd0, bus.is_stall}, 32'd0);
        chk("rst_mid_pending", bus.pending, 32'd0);
        chk("rst_mid_stats", bus.stall_cycles, 32'd0);
        tick();
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
